// File: rtl/tri_err_fir_rollup_if.sv
// Report channel between the FIR rollup and pervasive.
//
// Handshake: the master raises rpt_req together with rpt_type and holds both
// stable until it samples rpt_ack=1 on a rising clk edge; that edge completes
// the transfer. rpt_ack is a single-cycle pulse from the slave, and an
// rpt_ack seen while rpt_req=0 has no effect. rpt_type is 00 whenever
// rpt_req=0.
interface tri_err_fir_rollup_if;
  logic       rpt_req;
  logic [1:0] rpt_type;
  logic       rpt_ack;

  modport master (output rpt_req, output rpt_type, input rpt_ack);
  modport slave  (input rpt_req, input rpt_type, output rpt_ack);
endinterface

// File: rtl/tri_err_fir_rollup.sv
// tri_err_fir_rollup: collects masked error pulses from a group of report
// macros into a sticky FIR, captures the first-error index, counts
// recoverable events against a threshold, reports to pervasive over a
// req/ack channel and drives a sticky checkstop.
//
// Vectors are numbered [0:WIDTH-1], so index 0 is the leftmost (MSB) bit.
// Optional feature: define TRI_ERR_FIR_INJECT_EN to add the inj_err injection
// input and the inj_seen status output.
module tri_err_fir_rollup #(
  parameter int               WIDTH        = 8,
  parameter int               IDX_WIDTH    = 3,
  parameter int               CNT_WIDTH    = 4,
  parameter int               THRESHOLD    = 8,
  parameter logic [0:WIDTH-1] CHKSTOP_MASK = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [0:WIDTH-1]     err_in,
`ifdef TRI_ERR_FIR_INJECT_EN
  input  logic [0:WIDTH-1]     inj_err,
  output logic                 inj_seen,
`endif
  input  logic                 clr_fir,
  output logic [0:WIDTH-1]     fir_out,
  output logic                 first_valid,
  output logic [IDX_WIDTH-1:0] first_idx,
  output logic [CNT_WIDTH-1:0] rec_cnt,
  tri_err_fir_rollup_if.master rpt,
  output logic                 chkstop_out,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REC_REQ  = 2'd1,
    CHK_REQ  = 2'd2,
    CHK_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH:0] THR_W = (CNT_WIDTH+1)'(THRESHOLD);

  state_t               state, state_nxt;
  logic                 chk_pend, chk_pend_nxt;
  logic [0:WIDTH-1]     err_eff;
  logic                 rec_ev, chk_ev, thr_ev, chk_any;
  logic                 in_chk, clr_eff;
  logic [IDX_WIDTH-1:0] low_idx;
  logic [CNT_WIDTH-1:0] cnt_base, cnt_nxt;
  logic [CNT_WIDTH:0]   cnt_inc;

`ifdef TRI_ERR_FIR_INJECT_EN
  assign err_eff = err_in | inj_err;
`else
  assign err_eff = err_in;
`endif

  assign rec_ev  = |(err_eff & ~CHKSTOP_MASK);
  assign chk_ev  = |(err_eff & CHKSTOP_MASK);

  // Once a checkstop is being reported the error state is frozen for
  // firmware to inspect, so SCOM clears are dropped.
  assign in_chk  = (state == CHK_REQ) || (state == CHK_HOLD);
  assign clr_eff = clr_fir && !in_chk;

  // Lowest set index of the effective error vector (index 0 wins).
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (err_eff[i]) low_idx = IDX_WIDTH'(i);
    end
  end

  // Counter next value; a clear in the same cycle makes the count restart,
  // and the threshold test uses that restarted base. The extra bit keeps a
  // saturated counter from wrapping into a false threshold match.
  always_comb begin
    cnt_base = clr_eff ? '0 : rec_cnt;
    cnt_inc  = {1'b0, cnt_base} + {{CNT_WIDTH{1'b0}}, 1'b1};
    cnt_nxt  = cnt_base;
    if (rec_ev && !(&cnt_base)) cnt_nxt = cnt_inc[CNT_WIDTH-1:0];
  end

  assign thr_ev  = rec_ev && (cnt_inc == THR_W);
  assign chk_any = chk_ev || thr_ev;

  // Sticky FIR; an error arriving with the clear survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fir_out <= '0;
    else        fir_out <= (clr_eff ? '0 : fir_out) | err_eff;
  end

  // First-error capture, held until a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_valid <= 1'b0;
      first_idx   <= '0;
    end else if ((!first_valid || clr_eff) && (|err_eff)) begin
      first_valid <= 1'b1;
      first_idx   <= low_idx;
    end else if (clr_eff) begin
      first_valid <= 1'b0;
      first_idx   <= '0;
    end
  end

  // Saturating recoverable event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rec_cnt <= '0;
    else        rec_cnt <= cnt_nxt;
  end

`ifdef TRI_ERR_FIR_INJECT_EN
  // Remembers that SCOM injection was used since the last clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          inj_seen <= 1'b0;
    else if (|inj_err)   inj_seen <= 1'b1;
    else if (clr_fir)    inj_seen <= 1'b0;
  end
`endif

  // Report FSM state and pending-checkstop registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      chk_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      chk_pend <= chk_pend_nxt;
    end
  end

  // Report FSM next state; outputs decode only the state register so they
  // never see a combinational path from err_in or rpt_ack.
  always_comb begin
    state_nxt    = state;
    chk_pend_nxt = chk_pend;
    rpt.rpt_req  = 1'b0;
    rpt.rpt_type = 2'b00;
    chkstop_out  = 1'b0;
    case (state)
      IDLE: begin
        if (chk_any)     state_nxt = CHK_REQ;
        else if (rec_ev) state_nxt = REC_REQ;
      end
      REC_REQ: begin
        rpt.rpt_req  = 1'b1;
        rpt.rpt_type = 2'b01;
        if (rpt.rpt_ack) begin
          state_nxt    = (chk_pend || chk_any) ? CHK_REQ : IDLE;
          chk_pend_nxt = 1'b0;
        end else if (chk_any) begin
          chk_pend_nxt = 1'b1;
        end
      end
      CHK_REQ: begin
        rpt.rpt_req  = 1'b1;
        rpt.rpt_type = 2'b10;
        chkstop_out  = 1'b1;
        if (rpt.rpt_ack) state_nxt = CHK_HOLD;
      end
      CHK_HOLD: begin
        chkstop_out = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_tri_err_fir_rollup.sv
// Directed bench for tri_err_fir_rollup. Instance a has an all-recoverable
// mask; instance b marks index 0 as checkstop class. Both share err/clr/ack.
module tb_tri_err_fir_rollup;

  localparam int W = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_REC = 2'd1, S_CREQ = 2'd2, S_HOLD = 2'd3;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:W-1] err = '0;
  logic         clr = 1'b0;
  logic         ack = 1'b0;

  tri_err_fir_rollup_if bus_a ();
  tri_err_fir_rollup_if bus_b ();
  assign bus_a.rpt_ack = ack;
  assign bus_b.rpt_ack = ack;

  logic [0:W-1] fir_a, fir_b;
  logic         fv_a, fv_b, chk_a, chk_b;
  logic [2:0]   idx_a, idx_b;
  logic [3:0]   cnt_a, cnt_b;
  logic [1:0]   st_a, st_b;

`ifdef TRI_ERR_FIR_INJECT_EN
  logic [0:W-1] inj = '0;
  logic         inj_seen_a, inj_seen_b;
`endif

  tri_err_fir_rollup #(.WIDTH(W), .IDX_WIDTH(3), .CNT_WIDTH(4), .THRESHOLD(8),
                       .CHKSTOP_MASK(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .err_in(err),
`ifdef TRI_ERR_FIR_INJECT_EN
    .inj_err(inj), .inj_seen(inj_seen_a),
`endif
    .clr_fir(clr), .fir_out(fir_a), .first_valid(fv_a), .first_idx(idx_a),
    .rec_cnt(cnt_a), .rpt(bus_a), .chkstop_out(chk_a), .state_dbg(st_a)
  );

  tri_err_fir_rollup #(.WIDTH(W), .IDX_WIDTH(3), .CNT_WIDTH(4), .THRESHOLD(8),
                       .CHKSTOP_MASK(8'h80)) dut_b (
    .clk(clk), .rst_n(rst_n), .err_in(err),
`ifdef TRI_ERR_FIR_INJECT_EN
    .inj_err(inj), .inj_seen(inj_seen_b),
`endif
    .clr_fir(clr), .fir_out(fir_b), .first_valid(fv_b), .first_idx(idx_b),
    .rec_cnt(cnt_b), .rpt(bus_b), .chkstop_out(chk_b), .state_dbg(st_b)
  );

  // scoreboard
  logic [21:0] exp_q[$];
  bit          sel_q[$];
  string       tag_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  function automatic logic [21:0] pack(logic [7:0] fir, logic fv, logic [2:0] idx,
                                       logic [3:0] cnt, logic req, logic [1:0] typ,
                                       logic chk, logic [1:0] st);
    return {fir, fv, idx, cnt, req, typ, chk, st};
  endfunction

  function automatic logic [21:0] observe(bit sel);
    if (sel) return {fir_b, fv_b, idx_b, cnt_b, bus_b.rpt_req, bus_b.rpt_type, chk_b, st_b};
    return {fir_a, fv_a, idx_a, cnt_a, bus_a.rpt_req, bus_a.rpt_type, chk_a, st_a};
  endfunction

  task automatic expect_snap(input string tag, input bit sel, input logic [21:0] e);
    exp_q.push_back(e);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    logic [21:0] e, o;
    bit          s;
    string       t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      t = tag_q.pop_front();
      o = observe(s);
      total_cnt++;
      assert (o === e) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", t, o, e);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    expect_snap("reset_a", 1'b0, pack(8'h00, 0, 0, 0, 0, 2'b00, 0, S_IDLE));
    expect_snap("reset_b", 1'b1, pack(8'h00, 0, 0, 0, 0, 2'b00, 0, S_IDLE));
    drain();
    rst_n = 1'b1;

    // single recoverable error at index 5, request held 4 cycles, then ack
    err = '0; err[5] = 1'b1;
    expect_snap("rec5_req", 1'b0, pack(8'h04, 1, 5, 1, 1, 2'b01, 0, S_REC));
    tick();
    err = '0;
    for (int i = 0; i < 4; i++) begin
      expect_snap("rec5_hold", 1'b0, pack(8'h04, 1, 5, 1, 1, 2'b01, 0, S_REC));
      tick();
    end
    ack = 1'b1;
    expect_snap("rec5_ack", 1'b0, pack(8'h04, 1, 5, 1, 0, 2'b00, 0, S_IDLE));
    tick();
    ack = 1'b0;

    // clear with no error present
    clr = 1'b1;
    expect_snap("clr_empty", 1'b0, pack(8'h00, 0, 0, 0, 0, 2'b00, 0, S_IDLE));
    tick();
    clr = 1'b0;

    // indices 2 and 6 together: lowest wins
    err = '0; err[2] = 1'b1; err[6] = 1'b1;
    expect_snap("idx_2_6", 1'b0, pack(8'h22, 1, 2, 1, 1, 2'b01, 0, S_REC));
    tick();
    err = '0; ack = 1'b1;
    expect_snap("idx_2_6_ack", 1'b0, pack(8'h22, 1, 2, 1, 0, 2'b00, 0, S_IDLE));
    tick();
    ack = 1'b0;
    err[1] = 1'b1;
    expect_snap("later_idx1", 1'b0, pack(8'h62, 1, 2, 2, 1, 2'b01, 0, S_REC));
    tick();
    err = '0; ack = 1'b1;
    expect_snap("later_idx1_ack", 1'b0, pack(8'h62, 1, 2, 2, 0, 2'b00, 0, S_IDLE));
    tick();
    ack = 1'b0; clr = 1'b1;
    expect_snap("clr_again", 1'b0, pack(8'h00, 0, 0, 0, 0, 2'b00, 0, S_IDLE));
    tick();
    clr = 1'b0; err[1] = 1'b1;
    expect_snap("recapture_idx1", 1'b0, pack(8'h40, 1, 1, 1, 1, 2'b01, 0, S_REC));
    tick();
    err = '0; ack = 1'b1;
    expect_snap("recapture_ack", 1'b0, pack(8'h40, 1, 1, 1, 0, 2'b00, 0, S_IDLE));
    tick();
    ack = 1'b0;

    // FIR full, then clear together with index 3
    err = 8'hFF;
    expect_snap("fir_full", 1'b0, pack(8'hFF, 1, 1, 2, 1, 2'b01, 0, S_REC));
    tick();
    err = '0; ack = 1'b1;
    expect_snap("fir_full_ack", 1'b0, pack(8'hFF, 1, 1, 2, 0, 2'b00, 0, S_IDLE));
    tick();
    ack = 1'b0; clr = 1'b1; err[3] = 1'b1;
    expect_snap("clr_with_err3", 1'b0, pack(8'h10, 1, 3, 1, 1, 2'b01, 0, S_REC));
    tick();
    clr = 1'b0; err = '0; ack = 1'b1;
    expect_snap("clr_with_err3_ack", 1'b0, pack(8'h10, 1, 3, 1, 0, 2'b00, 0, S_IDLE));
    tick();
    ack = 1'b0;

    // threshold escalation: eighth recoverable event raises a checkstop
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      err = '0; err[5] = 1'b1;
      if (k < 8)
        expect_snap("thr_pulse", 1'b0, pack(8'h04, 1, 5, 4'(k), 1, 2'b01, 0, S_REC));
      else
        expect_snap("thr_escalate", 1'b0, pack(8'h04, 1, 5, 4'(k), 1, 2'b10, 1, S_CREQ));
      tick();
      err = '0; ack = 1'b1;
      if (k < 8)
        expect_snap("thr_pulse_ack", 1'b0, pack(8'h04, 1, 5, 4'(k), 0, 2'b00, 0, S_IDLE));
      else
        expect_snap("thr_hold", 1'b0, pack(8'h04, 1, 5, 4'(k), 0, 2'b00, 1, S_HOLD));
      tick();
      ack = 1'b0;
    end
    clr = 1'b1;
    expect_snap("hold_ignores_clr", 1'b0, pack(8'h04, 1, 5, 8, 0, 2'b00, 1, S_HOLD));
    tick();
    clr = 1'b0;

    // checkstop-class error while a recoverable report is outstanding
    do_reset();
    err = '0; err[5] = 1'b1;
    expect_snap("b_rec", 1'b1, pack(8'h04, 1, 5, 1, 1, 2'b01, 0, S_REC));
    tick();
    err = '0; err[0] = 1'b1;
    expect_snap("b_chk_pending", 1'b1, pack(8'h84, 1, 5, 1, 1, 2'b01, 0, S_REC));
    tick();
    err = '0;
    expect_snap("b_still_rec", 1'b1, pack(8'h84, 1, 5, 1, 1, 2'b01, 0, S_REC));
    tick();
    ack = 1'b1;
    expect_snap("b_to_chk", 1'b1, pack(8'h84, 1, 5, 1, 1, 2'b10, 1, S_CREQ));
    tick();
    ack = 1'b0;
    expect_snap("b_chk_stable", 1'b1, pack(8'h84, 1, 5, 1, 1, 2'b10, 1, S_CREQ));
    tick();

    // asynchronous reset while in CHK_REQ
    #2;
    rst_n = 1'b0;
    #1;
    expect_snap("b_async_rst", 1'b1, pack(8'h00, 0, 0, 0, 0, 2'b00, 0, S_IDLE));
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_snap("b_after_rst", 1'b1, pack(8'h00, 0, 0, 0, 0, 2'b00, 0, S_IDLE));
    tick();

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tri_err_fir_rollup.md
Name: tri_err_fir_rollup

Overview:
- Downstream collector for a group of error-report macros. Takes their masked err_out vectors (err_in here).
- Keeps a sticky fault isolation register (FIR) and captures the first-error index.
- Counts recoverable events against a threshold and escalates on overflow.
- Raises classified reports to pervasive over a req/ack handshake; drives a sticky checkstop.

Parameters:
- WIDTH, 8, number of error inputs; 1..32.
- IDX_WIDTH, 3, first-error index width; ceil(log2(WIDTH)), minimum 1.
- CNT_WIDTH, 4, recoverable event counter width.
- THRESHOLD, 8, recoverable count that escalates to checkstop; 1..2^CNT_WIDTH-1.
- CHKSTOP_MASK, all 0, per-bit class; 1 = checkstop class, 0 = recoverable.

Ports:
- clk  in  1  block clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- err_in  in  WIDTH  masked error pulses from the report macros, bit 0 = index 0.
- clr_fir  in  1  single-cycle pulse from SCOM; clears FIR, first-error, counter.
- fir_out  out  WIDTH  sticky FIR.
- first_valid  out  1  first-error capture valid.
- first_idx  out  IDX_WIDTH  index of the first error.
- rec_cnt  out  CNT_WIDTH  saturating recoverable event count.
- rpt_req  out  1  report request to pervasive.
- rpt_type  out  2  01 = recoverable, 10 = checkstop; 00 when rpt_req=0.
- rpt_ack  in  1  report acknowledge, one cycle.
- chkstop_out  out  1  sticky checkstop.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n). While rst_n=0, every register and every output is 0 and the FSM is in IDLE.
- Event terms: rec_ev = |(err_in & ~CHKSTOP_MASK); chk_ev = |(err_in & CHKSTOP_MASK).
- FIR: fir <= (clr_fir ? 0 : fir) | err_in. An error in the same cycle as clr_fir survives. err_in at cycle N is visible on fir_out at N+1.
- First-error capture:
  - If first_valid=0 (or clr_fir=1) and err_in != 0, capture the lowest set index and set first_valid.
  - The capture holds until clr_fir.
  - clr_fir with no error present clears first_valid and first_idx.
- Counter:
  - rec_cnt += 1 on each cycle with rec_ev=1 (one per cycle, regardless of how many bits are set). Saturates at all-ones.
  - clr_fir zeroes the counter; a simultaneous rec_ev loads 1.
  - thr_ev = (rec_ev=1 and rec_cnt+1 == THRESHOLD) is a one-cycle pulse and counts as a checkstop event.
- FSM states: IDLE, REC_REQ, CHK_REQ, CHK_HOLD.
  - IDLE: chk_ev|thr_ev -> CHK_REQ. Otherwise rec_ev -> REC_REQ.
  - REC_REQ: rpt_req=1, rpt_type=01.
    - rpt_req and rpt_type stay stable until rpt_ack.
    - Further rec_ev coalesce; no queueing.
    - chk_ev|thr_ev sets chk_pend.
    - On rpt_ack: chk_pend (or chk_ev|thr_ev in the same cycle) -> CHK_REQ; otherwise IDLE.
  - CHK_REQ: rpt_req=1, rpt_type=10, chkstop_out=1. On rpt_ack -> CHK_HOLD.
  - CHK_HOLD: rpt_req=0, chkstop_out=1. Terminal until reset.
- FSM outputs are registered: rpt_req rises 1 cycle after the triggering err_in.
- rpt_ack is ignored in IDLE and CHK_HOLD.
- clr_fir is ignored for the FIR, counter and first-error capture while in CHK_REQ or CHK_HOLD; it never changes FSM state.
- A mid-operation reset (rst_n low during REC_REQ or CHK_REQ) drops rpt_req in the same cycle, with no ack required.

Optional Feature:
- Macro: TRI_ERR_FIR_INJECT_EN.
- Defined:
  - Adds input inj_err [WIDTH] (SCOM injection pulses).
  - The effective error vector is err_in | inj_err everywhere: FIR, first-error capture, counter, FSM.
  - Adds output inj_seen (1 bit), which latches on any nonzero inj_err, clears on clr_fir, and resets to 0.
- Undefined: no extra ports; behaviour exactly as described above.

Test Plan:
- Reset then single rec bit 5, CHKSTOP_MASK=0: at N+1 fir_out=0x04 (bit 5 of [0:7]), first_idx=5, rec_cnt=1, rpt_req=1, rpt_type=01. Hold rpt_ack low 4 cycles: req stays stable. Ack -> IDLE.
- err_in bits 2 and 6 in the same cycle: first_idx=2. A later bit 1 leaves first_idx=2. clr_fir then bit 1: first_idx=1.
- THRESHOLD=8, 8 consecutive single-cycle rec pulses, each acked: the 8th cycle drives CHK_REQ (rpt_type=10, chkstop_out=1). Ack -> CHK_HOLD. Further clr_fir leaves fir_out unchanged.
- CHKSTOP_MASK bit 0 set: rec pulse, then while in REC_REQ pulse bit 0. rpt_type stays 01 until ack; next cycle rpt_type=10.
- clr_fir and err_in bit 3 in the same cycle, with FIR=0xFF in IDLE: fir_out=0x10, rec_cnt=1, first_idx=3.
- rst_n low for 1 cycle while in CHK_REQ: all outputs 0 asynchronously; after release, IDLE with no req.
